// File: rtl/ledsbin_ctrl.sv
// ledsbin_ctrl
//   Clocked, glitch-free switch-to-LED path. Each switch passes through a
//   two-flop synchroniser and a per-channel debouncer, then one of four
//   display modes drives the registered LED outputs.
//
// Ports
//   clk      in   system clock (single domain)
//   rst_n    in   asynchronous, active-low reset
//   sw       in   N raw switch inputs, asynchronous to clk
//   mode     in   display mode: 00 LIVE, 01 HOLD, 10 BLINK, 11 COUNT
//   load     in   level; high on an edge captures debounced switches into hold
//   led      out  N registered LED drive
//   changed  out  one-cycle pulse when any debounced bit changes
//   stable   out  high when every debounce counter is idle (zero)
//
// Handshake note: there is no valid/ready flow here. load is a plain level
// sampled on every edge, and changed is a single-cycle strobe that needs no
// acknowledgement.
module ledsbin_ctrl #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic [1:0]   mode,
  input  logic         load,
  output logic [N-1:0] led,
  output logic         changed,
  output logic         stable
);

  localparam logic [1:0] MODE_LIVE  = 2'b00;
  localparam logic [1:0] MODE_HOLD  = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // A one-cycle blink period still needs a 1-bit counter to be legal.
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [N-1:0]  sync1_q, sync1_d;
  logic [N-1:0]  sync2_q, sync2_d;
  logic [N-1:0]  deb_q, deb_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic          changed_q, changed_d;
  logic [N-1:0]  hold_q, hold_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [N-1:0]  chg_q, chg_d;
  logic [N-1:0]  led_q, led_d;

  // Synchroniser and debounce. A channel's counter only advances while its
  // synchronised input disagrees with the accepted value; any agreement
  // restarts it, so a glitch shorter than DEBOUNCE_CYCLES is never accepted.
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // One pulse regardless of how many channels flip on the same edge.
    changed_d = (deb_d != deb_q);
  end

  always_comb begin
    stable = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (cnt_q[i] != '0) stable = 1'b0;
    end
  end

  // Hold, blink phase and change counter run in every mode, so switching
  // modes never shows a stale or half-updated value.
  always_comb begin
    hold_d  = load ? deb_q : hold_q;
    chg_d   = chg_q + N'(changed_q);
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BLINK_MAX) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    led_d = deb_q;
    case (mode)
      MODE_LIVE:  led_d = deb_q;
      MODE_HOLD:  led_d = hold_q;
      MODE_BLINK: led_d = deb_q & {N{phase_q}};
      MODE_COUNT: led_d = chg_q;
      default:    led_d = deb_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      changed_q <= 1'b0;
      hold_q    <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b1;
      chg_q     <= '0;
      led_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      changed_q <= changed_d;
      hold_q    <= hold_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      chg_q     <= chg_d;
      led_q     <= led_d;
    end
  end

  assign led     = led_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_ledsbin_ctrl.sv
module tb_ledsbin_ctrl;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int BD = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw = '0;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [N-1:0] led;
  logic         changed;
  logic         stable;

  always #5 clk = ~clk;

  ledsbin_ctrl #(.N(N), .DEBOUNCE_CYCLES(D), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .load(load),
    .led(led), .changed(changed), .stable(stable)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Expected {led, changed, stable} after each edge out of reset.
  logic [N+1:0] exp_q[$];

  logic [N-1:0] m_s1, m_s2, m_deb, m_hold, m_chg, m_led;
  logic [N-1:0] m_hist[$];   // pre-edge synchronised samples, newest last
  logic         m_changed;
  int           m_edges;     // edges since reset release
  logic [N-1:0] n_deb, n_led;
  logic         all_diff, ph_old;

  // Blink phase purely as a function of elapsed edges: on for the first BD.
  function automatic logic phase_after(input int k);
    return ((k / BD) % 2) == 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_hold = '0; m_chg = '0; m_led = '0;
      m_changed = 1'b0; m_edges = 0;
      m_hist.delete();
      exp_q.delete();
    end else begin
      // A channel accepts a new value once D consecutive samples disagree.
      m_hist.push_back(m_s2);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      n_deb = m_deb;
      if (m_hist.size() == D) begin
        for (int i = 0; i < N; i++) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) n_deb[i] = ~m_deb[i];
        end
      end
      ph_old = phase_after(m_edges);
      case (mode)
        2'b00: n_led = m_deb;
        2'b01: n_led = m_hold;
        2'b10: n_led = ph_old ? m_deb : '0;
        default: n_led = m_chg;
      endcase
      exp_q.push_back({n_led, (n_deb != m_deb), (m_s2 == n_deb)});
      m_chg     = m_chg + (m_changed ? 1 : 0);
      if (load) m_hold = m_deb;
      m_changed = (n_deb != m_deb);
      m_s2      = m_s1;
      m_s1      = sw;
      m_deb     = n_deb;
      m_led     = n_led;
      m_edges++;
    end
  end

  // Monitor: compares DUT outputs just after every edge.
  logic [N+1:0] mon_exp;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_out", {led, changed, stable}, {{N{1'b0}}, 1'b0, 1'b1});
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_led_chg_stb", {led, changed, stable}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset in LIVE mode and check the first debounce latency by hand.
  task automatic release_check(input logic [N-1:0] exp_led);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    check("latency_led_e17", led, '0);
    check("latency_chg_e17", changed, 1'b1);
    @(posedge clk);
    #1;
    check("latency_led_e18", led, exp_led);
    @(negedge clk);
  endtask

  task automatic toggle_hold(input logic [N-1:0] mask, input int n);
    sw = sw ^ mask;
    cyc(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with switches already set, then LIVE latency.
    sw = 4'b1101; mode = 2'b00; load = 1'b0; rst_n = 1'b0;
    cyc(3);
    #1;
    check("rst_led", led, '0);
    check("rst_stable", stable, 1'b1);
    release_check(4'b1101);

    // Glitch of 15 cycles on bit0 must be filtered.
    sw = 4'b1100; cyc(40);
    sw = 4'b1101; cyc(15);
    sw = 4'b1100; cyc(30);
    check("glitch_led", led, 4'b1100);

    // HOLD.
    mode = 2'b01;
    sw = 4'b0011; cyc(30);
    load = 1'b1; cyc(1); load = 1'b0;
    sw = 4'b1100; cyc(30);
    check("hold_keep", led, 4'b0011);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk); #1;
    check("hold_reload", led, 4'b1100);
    cyc(3);

    // BLINK.
    sw = 4'b1111; mode = 2'b10; cyc(60);

    // COUNT from a fresh reset so the tally starts at zero.
    rst_n = 1'b0; sw = '0; mode = 2'b11; cyc(3);
    rst_n = 1'b1; cyc(5);
    for (int t = 0; t < 5; t++) toggle_hold(4'b0010, 25);
    toggle_hold(4'b1100, 25);
    check("count_six", led, 4'b0110);
    for (int t = 0; t < 10; t++) toggle_hold(4'b0001, 25);
    check("count_wrap", led, 4'b0000);

    // Reset in the middle of a bit2 debounce.
    mode = 2'b00; sw = '0; cyc(25);
    sw = 4'b0100; cyc(10);
    rst_n = 1'b0;
    #1;
    check("midrst_led", led, '0);
    check("midrst_changed", changed, 1'b0);
    check("midrst_stable", stable, 1'b1);
    cyc(3);
    release_check(4'b0100);

    // Randomised segments across all modes.
    for (int s = 0; s < 80; s++) begin
      sw   = N'($urandom_range(0, (1 << N) - 1));
      mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < $urandom_range(1, 40); c++) begin
        load = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
      load = 1'b0;
    end

    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ledsbin_ctrl.md
# ledsbin_ctrl

Parametrised successor to the switch-to-LED binary display: maps N slide switches to N LEDs through a synchroniser and per-channel debouncer, then applies one of four display modes (live, hold, blink, change-count). Sits between the board switch pins and the LED pins in the top level, and replaces the purely combinational switch-to-LED path with a clocked, glitch-free one.

## Interface

Parameters:
- N, 4, number of switch/LED channels (1..16)
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised switch must differ from its debounced value before the change is accepted (>=1)
- BLINK_DIV, 8, cycles per blink half-period (>=1)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- sw  in  N  raw switch inputs, asynchronous to clk
- mode  in  2  display mode: 00 LIVE, 01 HOLD, 10 BLINK, 11 COUNT; synchronous to clk
- load  in  1  synchronous level; high in a cycle captures debounced switches into the hold register
- led  out  N  registered LED drive
- changed  out  1  one-cycle pulse when any debounced bit changes
- stable  out  1  high when every channel's debounce counter is 0

## Operation

- Sync: two flip-flops per bit (sync1, sync2), reset 0.
- Debounce, per channel i: counter cnt[i], width $clog2(DEBOUNCE_CYCLES+1).
  - sync2[i] == deb[i]: cnt[i] <= 0.
  - sync2[i] != deb[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != deb[i] and cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync2[i], cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches deb.
- changed: registered, high in the cycle deb shows a new value; several channels changing on the same edge give one pulse.
- stable: combinational AND of all cnt[i]==0.
- Hold register hold[N-1:0], reset 0: hold <= deb on any edge with load=1, in every mode. Uses the pre-edge deb value if deb updates on the same edge. Not cleared on mode change.
- Blink phase: counter 0..BLINK_DIV-1 wraps; phase bit toggles on wrap; reset phase=1 (LEDs on).
- Change counter chg[N-1:0], reset 0: increments by 1 per changed pulse, wraps 2^N-1 -> 0; runs in every mode.
- LED next value, registered:
  - LIVE: deb.
  - HOLD: hold.
  - BLINK: deb & {N{phase}}.
  - COUNT: chg.
- mode is sampled every edge; a change is visible on led one edge later, with no glitch state.

## Timing

- Reset (rst_n=0, async): sync1, sync2, deb, cnt, hold, chg, blink counter = 0; phase=1; led=0, changed=0; stable=1.
- Release: first active edge after rst_n rises; no output changes until a switch input is 1.
- Latency, LIVE: sw change is captured by sync1 at edge E. deb updates at edge E+1+DEBOUNCE_CYCLES, with changed high in the following cycle. led updates at edge E+2+DEBOUNCE_CYCLES. With default parameters, led follows 18 edges after E.
- COUNT: chg updates on the edge after changed is high; led updates one edge after that.
- HOLD: load high at edge L -> hold valid after L; led = hold after edge L+1.
- BLINK: the phase bit stays in each state for BLINK_DIV cycles; led lags the phase bit by one edge.
- A reset asserted mid-debounce discards the partial count; the switch must then be stable for the full DEBOUNCE_CYCLES again after release.

## Test plan

- Reset with sw=4'b1101 held -> led=0, changed=0, stable=1 during reset. After release in LIVE, led=4'b1101 exactly 18 edges after the first sampling edge, with one changed pulse.
- LIVE, bit0 pulsed high for 15 cycles then low -> deb, led and changed never change; stable goes low then returns to 1.
- HOLD: sw=4'b0011 debounced, load pulse, then sw=4'b1100 debounced -> led stays 4'b0011. A second load -> led=4'b1100 one edge after hold updates.
- BLINK with sw=4'b1111, BLINK_DIV=8 -> led alternates 4'b1111 and 4'b0000, 8 cycles each, starting with the on phase after reset.
- COUNT: toggle bit1 five times, each toggle held more than 16 cycles; toggle bits 2 and 3 together once -> led=4'b0110 (6 counts). Further toggles wrap the count 15 -> 0.
- Assert rst_n=0 midway through a 10-cycle-old debounce of bit2 -> all outputs return to their reset values immediately. After release, bit2 needs a full 16 stable cycles to reach deb.
